// File: rtl/ov9281_init_seq.sv
// OV9281 power-up sequencer: walks a synchronous register-table ROM and issues SCCB
// writes/read-verifies over a valid/ready command port, with ms delays, NACK retries and sticky status.
module ov9281_init_seq #(
  parameter int unsigned CLK_SPEED      = 50000000,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ROM_ADDR_WIDTH = 8,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned RSP_TIMEOUT    = 65535
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [2:0]                o_err_code,
  output logic [ROM_ADDR_WIDTH-1:0] o_err_index,
  output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0]     i_rom_data,
  output logic                      o_cmd_valid,
  input  logic                      i_cmd_ready,
  output logic                      o_cmd_rw,
  output logic [15:0]               o_cmd_reg_addr,
  output logic [7:0]                o_cmd_wdata,
  input  logic                      i_rsp_valid,
  input  logic                      i_rsp_nack,
  input  logic [7:0]                i_rsp_rdata
);

  localparam int unsigned TICK_CYCLES = ((CLK_SPEED / 1000) > 0) ? (CLK_SPEED / 1000) : 1;
  localparam int unsigned TICK_W      = ($clog2(TICK_CYCLES + 1) > 0) ? $clog2(TICK_CYCLES + 1) : 1;
  localparam int unsigned TMO_LAST    = (RSP_TIMEOUT > 0) ? (RSP_TIMEOUT - 1) : 0;
  localparam int unsigned TMO_W       = ($clog2(RSP_TIMEOUT + 1) > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int unsigned RTRY_W      = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_DELAY  = 2'b01;
  localparam logic [1:0] OP_END    = 2'b10;
  localparam logic [1:0] OP_VERIFY = 2'b11;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_NACK    = 3'b001;
  localparam logic [2:0] ERR_VERIFY  = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_OVERRUN = 3'b100;

  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_INDEX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RSP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t                    r_state, w_state;
  logic [ROM_ADDR_WIDTH-1:0] r_index, w_index;
  logic [RTRY_W-1:0]         r_retry, w_retry;
  logic [TMO_W-1:0]          r_timer, w_timer;
  logic [TICK_W-1:0]         r_tick, w_tick;
  logic [15:0]               r_ms, w_ms;
  logic [7:0]                r_exp_data, w_exp_data;
  logic                      r_busy, w_busy;
  logic                      r_done, w_done;
  logic                      r_error, w_error;
  logic [2:0]                r_err_code, w_err_code;
  logic [ROM_ADDR_WIDTH-1:0] r_err_index, w_err_index;
  logic                      r_cmd_valid, w_cmd_valid;
  logic                      r_cmd_rw, w_cmd_rw;
  logic [15:0]               r_cmd_reg_addr, w_cmd_reg_addr;
  logic [7:0]                r_cmd_wdata, w_cmd_wdata;

  logic                      w_advance;
  logic                      w_fail;
  logic [2:0]                w_fail_code;
  logic [1:0]                w_op;
  logic                      w_unused_rom_bits;

  assign w_op              = i_rom_data[31:30];
  assign w_unused_rom_bits = ^i_rom_data;

  // Next-state and next-register logic
  always_comb begin
    w_state        = r_state;
    w_index        = r_index;
    w_retry        = r_retry;
    w_timer        = r_timer;
    w_tick         = r_tick;
    w_ms           = r_ms;
    w_exp_data     = r_exp_data;
    w_done         = r_done;
    w_error        = r_error;
    w_err_code     = r_err_code;
    w_err_index    = r_err_index;
    w_cmd_rw       = r_cmd_rw;
    w_cmd_reg_addr = r_cmd_reg_addr;
    w_cmd_wdata    = r_cmd_wdata;
    w_advance      = 1'b0;
    w_fail         = 1'b0;
    w_fail_code    = ERR_NONE;
    w_busy         = 1'b0;
    w_cmd_valid    = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state     = S_FETCH;
          w_index     = '0;
          w_done      = 1'b0;
          w_error     = 1'b0;
          w_err_code  = ERR_NONE;
          w_err_index = '0;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        w_retry    = '0;
        w_exp_data = i_rom_data[7:0];
        w_ms       = i_rom_data[15:0];
        w_tick     = '0;
        case (w_op)
          OP_WRITE, OP_VERIFY: begin
            w_state        = S_ISSUE;
            w_cmd_rw       = (w_op == OP_VERIFY);
            w_cmd_reg_addr = i_rom_data[23:8];
            w_cmd_wdata    = (w_op == OP_VERIFY) ? 8'h00 : i_rom_data[7:0];
          end
          OP_DELAY: w_state = S_DELAY;
          default: begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        endcase
      end
      S_ISSUE: begin
        if (i_cmd_ready) begin
          w_state = S_WAIT_RSP;
          w_timer = '0;
        end
      end
      S_WAIT_RSP: begin
        // A response arriving on the last timeout cycle still counts
        if (i_rsp_valid) begin
          if (i_rsp_nack) begin
            if (r_retry < RTRY_W'(MAX_RETRIES)) begin
              w_retry = r_retry + RTRY_W'(1);
              w_state = S_ISSUE;
            end else begin
              w_fail      = 1'b1;
              w_fail_code = ERR_NACK;
            end
          end else if (r_cmd_rw && (i_rsp_rdata != r_exp_data)) begin
            w_fail      = 1'b1;
            w_fail_code = ERR_VERIFY;
          end else begin
            w_advance = 1'b1;
          end
        end else if (r_timer == TMO_W'(TMO_LAST)) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_timer = r_timer + TMO_W'(1);
        end
      end
      S_DELAY: begin
        if (r_ms == 16'd0) begin
          w_advance = 1'b1;
        end else if (r_tick == TICK_W'(TICK_CYCLES - 1)) begin
          w_tick = '0;
          w_ms   = r_ms - 16'd1;
        end else begin
          w_tick = r_tick + TICK_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Step to the next entry; the table never wraps past its last slot
    if (w_advance) begin
      if (r_index == LAST_INDEX) begin
        w_fail      = 1'b1;
        w_fail_code = ERR_OVERRUN;
      end else begin
        w_index = r_index + ROM_ADDR_WIDTH'(1);
        w_state = S_FETCH;
      end
    end

    if (w_fail) begin
      w_state     = S_ERROR;
      w_error     = 1'b1;
      w_err_code  = w_fail_code;
      w_err_index = r_index;
    end

    w_busy      = (w_state inside {S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RSP, S_DELAY});
    w_cmd_valid = (w_state == S_ISSUE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_index        <= '0;
      r_retry        <= '0;
      r_timer        <= '0;
      r_tick         <= '0;
      r_ms           <= '0;
      r_exp_data     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_code     <= ERR_NONE;
      r_err_index    <= '0;
      r_cmd_valid    <= 1'b0;
      r_cmd_rw       <= 1'b0;
      r_cmd_reg_addr <= '0;
      r_cmd_wdata    <= '0;
    end else begin
      r_state        <= w_state;
      r_index        <= w_index;
      r_retry        <= w_retry;
      r_timer        <= w_timer;
      r_tick         <= w_tick;
      r_ms           <= w_ms;
      r_exp_data     <= w_exp_data;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_error        <= w_error;
      r_err_code     <= w_err_code;
      r_err_index    <= w_err_index;
      r_cmd_valid    <= w_cmd_valid;
      r_cmd_rw       <= w_cmd_rw;
      r_cmd_reg_addr <= w_cmd_reg_addr;
      r_cmd_wdata    <= w_cmd_wdata;
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_err_code     = r_err_code;
  assign o_err_index    = r_err_index;
  assign o_rom_addr     = r_index;
  assign o_cmd_valid    = r_cmd_valid;
  assign o_cmd_rw       = r_cmd_rw;
  assign o_cmd_reg_addr = r_cmd_reg_addr;
  assign o_cmd_wdata    = r_cmd_wdata;

endmodule

// File: tb/tb_ov9281_init_seq.sv
// Bench for ov9281_init_seq: directed vector table plus randomized tables/responses
// checked against a table-walking reference model; ROM and SCCB master are modelled here.
module tb_ov9281_init_seq;

  localparam int unsigned AW   = 2;
  localparam int unsigned MAXR = 2;
  localparam int          NV   = 14;
  localparam int          NRND = 30;
  localparam logic [1:0]  K_ACK = 2'd0, K_NACK = 2'd1, K_TO = 2'd2, K_BAD = 2'd3;

  typedef struct packed { logic [1:0] kind; logic [4:0] lat; logic [3:0] stall; } rsp_t;
  typedef logic [3:0][31:0] rom_t;
  typedef rsp_t [15:0] scr_t;
  typedef struct {
    rom_t       rom;
    scr_t       scr;
    int         extra_start;
    bit         exp_done;
    logic [2:0] exp_code;
    logic [1:0] exp_idx;
    int         exp_ncmd;
  } vec_t;

  logic          i_clk, i_rst, i_start;
  logic          o_busy, o_done, o_error;
  logic [2:0]    o_err_code;
  logic [AW-1:0] o_err_index, o_rom_addr;
  logic [31:0]   i_rom_data;
  logic          o_cmd_valid, i_cmd_ready, o_cmd_rw;
  logic [15:0]   o_cmd_reg_addr;
  logic [7:0]    o_cmd_wdata;
  logic          i_rsp_valid, i_rsp_nack;
  logic [7:0]    i_rsp_rdata;

  ov9281_init_seq #(
    .CLK_SPEED(4000), .DATA_WIDTH(32), .ROM_ADDR_WIDTH(AW), .MAX_RETRIES(MAXR), .RSP_TIMEOUT(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_code(o_err_code), .o_err_index(o_err_index),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_rw(o_cmd_rw),
    .o_cmd_reg_addr(o_cmd_reg_addr), .o_cmd_wdata(o_cmd_wdata),
    .i_rsp_valid(i_rsp_valid), .i_rsp_nack(i_rsp_nack), .i_rsp_rdata(i_rsp_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model results: expected command stream and final status
  int          exp_n;
  logic        exp_rw    [16];
  logic [15:0] exp_addr  [16];
  logic [7:0]  exp_wdata [16];
  logic [1:0]  exp_kind  [16];
  logic [7:0]  exp_rdata [16];
  logic [4:0]  exp_lat   [16];
  logic [3:0]  exp_stall [16];
  bit          exp_done;
  logic [2:0]  exp_code;
  logic [1:0]  exp_idx;

  // SCCB master / ROM model state
  rom_t        cur_rom;
  int          rom_addr_d = 0;
  int          hs, pend_cnt, stall_cnt;
  bit          pend, in_cmd;
  logic [1:0]  pend_kind;
  logic [7:0]  pend_rdata;
  logic [24:0] cap_fields;

  vec_t v [NV];
  int   dcyc [NV];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [15:0] a, input logic [7:0] d);
    return {2'b00, 6'd0, a, d};
  endfunction
  function automatic logic [31:0] vf(input logic [15:0] a, input logic [7:0] d);
    return {2'b11, 6'd0, a, d};
  endfunction
  function automatic logic [31:0] dly(input logic [15:0] ms);
    return {2'b01, 14'd0, ms};
  endfunction
  function automatic logic [31:0] en();
    return {2'b10, 30'd0};
  endfunction

  // Walks the table entry by entry, consuming one scripted response per command
  task automatic model(input rom_t rom, input scr_t scr);
    int idx, k, tries;
    logic [31:0] e;
    logic [1:0]  op;
    bit fin, again;
    idx = 0; k = 0; fin = 0;
    exp_n = 0; exp_done = 0; exp_code = 3'd0;
    while (!fin) begin
      e  = rom[idx];
      op = e[31:30];
      if (op == 2'b10) begin
        exp_done = 1; fin = 1;
      end else begin
        again = (op == 2'b00) || (op == 2'b11);
        tries = 0;
        while (again) begin
          exp_rw[exp_n]    = (op == 2'b11);
          exp_addr[exp_n]  = e[23:8];
          exp_wdata[exp_n] = (op == 2'b11) ? 8'h00 : e[7:0];
          exp_kind[exp_n]  = scr[k].kind;
          exp_lat[exp_n]   = scr[k].lat;
          exp_stall[exp_n] = scr[k].stall;
          exp_rdata[exp_n] = (scr[k].kind == K_BAD) ? (e[7:0] ^ 8'h01) : e[7:0];
          exp_n++;
          again = 0;
          case (scr[k].kind)
            K_NACK: if (tries < int'(MAXR)) begin tries++; again = 1; end
                    else begin fin = 1; exp_code = 3'd1; end
            K_TO:   begin fin = 1; exp_code = 3'd3; end
            K_BAD:  if (op == 2'b11) begin fin = 1; exp_code = 3'd2; end
            default: ;
          endcase
          k++;
        end
        if (!fin) begin
          if (idx == 3) begin fin = 1; exp_code = 3'd4; end
          else idx++;
        end
      end
    end
    exp_idx = 2'(idx);
  endtask

  // One negedge of the ROM and SCCB master models
  task automatic master_step();
    i_rom_data  = cur_rom[rom_addr_d];
    rom_addr_d  = int'(o_rom_addr);
    i_rsp_valid = 1'b0;
    i_rsp_nack  = 1'b0;
    i_rsp_rdata = 8'h00;
    if (pend) begin
      if (pend_cnt == 0) begin
        i_rsp_valid = 1'b1;
        i_rsp_nack  = (pend_kind == K_NACK);
        i_rsp_rdata = pend_rdata;
        pend = 0;
      end else pend_cnt--;
    end
    i_cmd_ready = 1'b0;
    if (in_cmd) begin
      check("cmd_valid_held", o_cmd_valid, 1);
      if (o_cmd_valid) check("cmd_stable", {o_cmd_rw, o_cmd_reg_addr, o_cmd_wdata}, cap_fields);
      else in_cmd = 0;
    end
    if (o_cmd_valid) begin
      if (!in_cmd) begin
        in_cmd     = 1;
        cap_fields = {o_cmd_rw, o_cmd_reg_addr, o_cmd_wdata};
        stall_cnt  = (hs < exp_n) ? int'(exp_stall[hs]) : 0;
      end
      if (stall_cnt > 0) stall_cnt--;
      else begin
        i_cmd_ready = 1'b1;
        in_cmd = 0;
        if (hs < exp_n) begin
          check($sformatf("cmd%0d_fields", hs), {o_cmd_rw, o_cmd_reg_addr, o_cmd_wdata},
                {exp_rw[hs], exp_addr[hs], exp_wdata[hs]});
          if (exp_kind[hs] != K_TO) begin
            pend = 1; pend_cnt = int'(exp_lat[hs]);
            pend_kind = exp_kind[hs]; pend_rdata = exp_rdata[hs];
          end
        end else begin
          check("extra_cmd", hs, exp_n);
          pend = 1; pend_cnt = 0; pend_kind = K_ACK; pend_rdata = 8'h00;
        end
        hs++;
      end
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    master_step();
  endtask

  task automatic run_seq(input string nm, input rom_t rom, input int extra_start,
                         input bit e_done, input logic [2:0] e_code, input logic [1:0] e_idx,
                         input int e_ncmd, output int cyc);
    cur_rom = rom; hs = 0; pend = 0; in_cmd = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({nm, ":busy"}, o_busy, 1);
    cyc = 1;
    while (!(o_done || o_error) && cyc < 800) begin
      if (cyc == extra_start) i_start = 1'b1;
      tick();
      i_start = 1'b0;
      cyc++;
    end
    check({nm, ":finished"}, o_done | o_error, 1);
    check({nm, ":done"}, o_done, e_done);
    check({nm, ":error"}, o_error, !e_done);
    check({nm, ":err_code"}, o_err_code, e_done ? 3'd0 : e_code);
    if (!e_done) check({nm, ":err_index"}, o_err_index, e_idx);
    check({nm, ":idle"}, {o_busy, o_cmd_valid}, 2'b00);
    check({nm, ":ncmd"}, hs, e_ncmd);
  endtask

  function automatic vec_t mk(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input bit d, input logic [2:0] c,
                              input logic [1:0] ix, input int n);
    vec_t t;
    t.rom = {e3, e2, e1, e0};
    t.scr = '0;
    t.extra_start = 0;
    t.exp_done = d; t.exp_code = c; t.exp_idx = ix; t.exp_ncmd = n;
    return t;
  endfunction

  initial begin
    rom_t rrom;
    scr_t rscr;
    int   cyc, cnt, r;

    i_rst = 1'b0; i_start = 1'b0; i_cmd_ready = 1'b0;
    i_rsp_valid = 1'b0; i_rsp_nack = 1'b0; i_rsp_rdata = 8'h00; i_rom_data = 32'd0;
    cur_rom = '0; hs = 0; pend = 0; in_cmd = 0; exp_n = 0;
    repeat (3) tick();
    check("reset_outputs", {o_busy, o_done, o_error, o_err_code, o_err_index, o_rom_addr,
                            o_cmd_valid, o_cmd_rw, o_cmd_reg_addr, o_cmd_wdata}, 36'd0);
    i_rst = 1'b1;
    tick();

    v[0]  = mk(wr(16'h0103, 8'h01), wr(16'h0100, 8'h01), en(), en(), 1, 3'd0, 2'd0, 2);
    v[1]  = mk(wr(16'h3500, 8'h12), en(), en(), en(), 1, 3'd0, 2'd0, 3);
    v[1].scr[0].kind = K_NACK; v[1].scr[1].kind = K_NACK;
    v[2]  = mk(wr(16'h3500, 8'h12), en(), en(), en(), 0, 3'd1, 2'd0, 3);
    v[2].scr[0].kind = K_NACK; v[2].scr[1].kind = K_NACK; v[2].scr[2].kind = K_NACK;
    v[3]  = mk(vf(16'h300A, 8'h92), en(), en(), en(), 0, 3'd2, 2'd0, 1);
    v[3].scr[0].kind = K_BAD;
    v[4]  = mk(wr(16'h0100, 8'h01), en(), en(), en(), 0, 3'd3, 2'd0, 1);
    v[4].scr[0].kind = K_TO;
    v[5]  = mk(wr(16'h0100, 8'h01), en(), en(), en(), 1, 3'd0, 2'd0, 1);
    v[5].scr[0].lat = 5'd15;
    v[6]  = mk(wr(16'h0001, 8'h11), wr(16'h0002, 8'h22), wr(16'h0003, 8'h33),
               wr(16'h0004, 8'h44), 0, 3'd4, 2'd3, 4);
    v[7]  = mk(wr(16'h1234, 8'h56), en(), en(), en(), 1, 3'd0, 2'd0, 1);
    v[7].scr[0].stall = 4'd5;
    v[8]  = mk(wr(16'h0001, 8'hAA), wr(16'h0002, 8'hBB), en(), en(), 1, 3'd0, 2'd0, 2);
    v[8].scr[0].lat = 5'd6; v[8].scr[1].lat = 5'd6; v[8].extra_start = 10;
    v[9]  = mk(dly(16'd0), en(), en(), en(), 1, 3'd0, 2'd0, 0);
    v[10] = mk(dly(16'd3), en(), en(), en(), 1, 3'd0, 2'd0, 0);
    v[11] = mk(dly(16'd1), vf(16'h4000, 8'h5A), en(), en(), 1, 3'd0, 2'd0, 1);
    v[12] = mk(vf(16'h300A, 8'h92), en(), en(), en(), 0, 3'd2, 2'd0, 2);
    v[12].scr[0].kind = K_NACK; v[12].scr[1].kind = K_BAD;
    v[13] = mk(wr(16'h0010, 8'h01), dly(16'd0), wr(16'h0020, 8'h02), en(), 0, 3'd3, 2'd2, 2);
    v[13].scr[1].kind = K_TO;

    for (int i = 0; i < NV; i++) begin
      model(v[i].rom, v[i].scr);
      run_seq($sformatf("vec%0d", i), v[i].rom, v[i].extra_start, v[i].exp_done,
              v[i].exp_code, v[i].exp_idx, v[i].exp_ncmd, cyc);
      dcyc[i] = cyc;
      tick(); tick();
    end
    check("delay3_minus_delay0", dcyc[10] - dcyc[9], 12);

    for (int n = 0; n < NRND; n++) begin
      for (int e = 0; e < 4; e++) begin
        r = $urandom_range(0, 9);
        if (r < 4)      rrom[e] = wr(16'($urandom), 8'($urandom));
        else if (r < 6) rrom[e] = vf(16'($urandom), 8'($urandom));
        else if (r < 8) rrom[e] = dly(16'($urandom_range(0, 2)));
        else            rrom[e] = en();
      end
      for (int j = 0; j < 16; j++) begin
        r = $urandom_range(0, 19);
        rscr[j].kind  = (r < 12) ? K_ACK : (r < 16) ? K_NACK : (r < 19) ? K_BAD : K_TO;
        rscr[j].lat   = 5'($urandom_range(0, 4));
        rscr[j].stall = 4'($urandom_range(0, 3));
      end
      model(rrom, rscr);
      run_seq($sformatf("rnd%0d", n), rrom, $urandom_range(2, 30), exp_done, exp_code,
              exp_idx, exp_n, cyc);
      tick();
    end

    // Reset while waiting for a response, then a clean restart from index 0
    rrom = {en(), en(), wr(16'h3333, 8'h44), wr(16'h1111, 8'h22)};
    rscr = '0;
    rscr[0].lat = 5'd10;
    model(rrom, rscr);
    cur_rom = rrom; hs = 0; pend = 0; in_cmd = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cnt = 0;
    while (hs == 0 && cnt < 50) begin tick(); cnt++; end
    check("rst:reached_wait", hs, 1);
    tick(); tick();
    i_rst = 1'b0;
    #1;
    check("rst:async_outputs", {o_busy, o_done, o_error, o_err_code, o_err_index, o_rom_addr,
                                o_cmd_valid, o_cmd_rw, o_cmd_reg_addr, o_cmd_wdata}, 36'd0);
    pend = 0; in_cmd = 0; hs = 0;
    tick(); tick();
    i_rst = 1'b1;
    tick();
    rscr[0].lat = 5'd0;
    model(rrom, rscr);
    run_seq("restart", rrom, 0, 1, 3'd0, 2'd0, 2, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
